ins_fetch_unit: RTL and testbench
=================================

# ins_fetch_unit

Parametrised, decoupled instruction-fetch stage for the multi-cycle CPU. It replaces the single-shot fetch path (PC → instruction memory → IR/NPC) with a PC sequencer, a request/acknowledge instruction-memory port, and a DEPTH-entry prefetch queue. It sits between the next-PC mux and decode. Decode consumes {opcode, remaining bits, NPC} through a valid/ready handshake, and control-flow redirects flush the queue.

## Interface
- ADDR_W, 32, PC and memory address width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PC_STEP, 4, sequential PC increment in bytes
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fecAbl  in  1  fetch enable; 0 = issue no new memory requests
- redirect  in  1  control-flow redirect strobe (1 cycle)
- muxFirOut  in  ADDR_W  redirect target PC, sampled when redirect=1
- memReq  out  1  instruction-memory request
- memAddr  out  ADDR_W  request address, stable while memReq=1
- memAck  in  1  response valid; only meaningful while memReq=1
- memData  in  32  instruction word, valid with memAck
- insValid  out  1  queue head valid to decode
- insReady  in  1  decode accepts head
- irOutOpe  out  6  head instruction [31:26]
- irOutOth  out  26  head instruction [25:0]
- npcOut  out  ADDR_W  head fetch PC + PC_STEP
- qCount  out  clog2(DEPTH)+1  current queue occupancy

## Operation
- At most one memory request is outstanding. memReq rises when fecAbl=1 and (qCount + outstanding) < DEPTH. It stays high, with memAddr fixed, until memAck.
- On an accepted ack, the unit pushes {memData, memAddr+PC_STEP} into the queue and advances the PC by PC_STEP, wrapping modulo 2^ADDR_W.
- Pop occurs when insValid & insReady. Push and pop may happen in the same cycle; occupancy is then unchanged, and a full queue may push if it pops in that cycle.
- A redirect clears the queue the next cycle (qCount=0, insValid=0) and sets PC to muxFirOut. The redirect has priority over any push or pop in the same cycle.
- Redirect with a request in flight: memReq is not withdrawn. The unit sets a drop flag, discards the matching ack, and issues the next request to the new target.
- Redirect in the same cycle as memAck: the ack data is discarded and no further drop is pending.
- fecAbl=0 stops new requests only. An in-flight request completes and pushes normally, and the queue continues draining.
- State machine: IDLE (no request) → REQ (memReq=1) on the issue condition. REQ → IDLE on memAck, or REQ → REQ if the issue condition still holds (back-to-back). DROP is the REQ-with-discard variant, entered on a redirect while in REQ.
- Reset values: memReq=0, memAddr=RESET_PC, insValid=0, irOutOpe=0, irOutOth=0, npcOut=0, qCount=0, state IDLE, drop=0. rst asserted mid-request abandons the request: memReq=0 next cycle and any later ack is ignored.

## Timing
- First memReq rises in cycle 1 after rst deasserts, with address RESET_PC.
- memAck may come in the same cycle as memReq (zero-wait) or later.
- Without bypass, memAck in cycle N gives insValid=1 in cycle N+1 on an empty queue.
- Zero-wait steady state gives one instruction per cycle when decode is always ready.
- Redirect in cycle N gives a new request to the target no earlier than N+1, or the cycle after a pending ack drains.

## Configuration
- FETCH_BYPASS_EN: when defined, an ack arriving while the queue is empty and insReady=1 drives insValid, irOut*, and npcOut combinationally from memData in the same cycle. The entry is not stored.
- When FETCH_BYPASS_EN is not defined, every instruction passes through the queue with a minimum one-cycle ack-to-valid latency.
- The redirect-drop rules apply in both builds.

## Structure
- Package ins_fetch_pkg:
  - OPC_W=6 and OTH_W=26.
  - typedef fetch_entry_t {instr[31:0], npc[ADDR_W-1:0]}.
  - typedef of the fetch state enum {IDLE, REQ, DROP}.
- Sub-module ins_fetch_fifo: a synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count, full, and empty. Flush overrides push and pop.

## Test plan
- Reset, zero-wait memory, insReady=1: addresses 0,4,8,12 on consecutive cycles. npcOut sequence is 4,8,12,16, with one instruction per cycle after the first.
- insReady=0, DEPTH=4: exactly 4 acks accepted, then memReq stays 0 and qCount=4. Raising insReady drains in order and resumes fetch at address 16.
- 3-cycle memory latency, redirect to 0x100 in the cycle after memReq rises: the ack of the old request is dropped and the next memAddr is 0x100. The first delivered npcOut is 0x104.
- Redirect coincident with memAck and with pop on a full queue: the next cycle shows qCount=0, insValid=0, and the PC at the target.
- fecAbl=0 with a request in flight: the request completes and is queued, and no further memReq occurs until fecAbl=1.
- rst asserted while memReq=1: the next cycle shows memReq=0 and memAddr=RESET_PC. A late memAck is ignored and qCount stays 0.

Source files
------------

// File: rtl/ins_fetch_pkg.sv
// rtl/ins_fetch_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Contents:
//   OPC_W / OTH_W   widths of the opcode and remaining-bits fields of an instruction
//   INSTR_W         instruction word width
//   FETCH_ADDR_W    width of the npc field carried through the prefetch queue
//   fetch_entry_t   one prefetch queue entry: {instr, npc}
//   fetch_state_t   fetch sequencer state: IDLE, REQ, DROP
package ins_fetch_pkg;

   localparam int OPC_W        = 6;
   localparam int OTH_W        = 26;
   localparam int INSTR_W      = 32;
   localparam int FETCH_ADDR_W = 32;

   typedef struct packed {
      logic [INSTR_W-1:0]      instr;
      logic [FETCH_ADDR_W-1:0] npc;
   } fetch_entry_t;

   // DROP is REQ with the pending ack marked for discard after a redirect.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
      return word[INSTR_W-1 -: OPC_W];
   endfunction

   function automatic logic [OTH_W-1:0] others_of(input logic [INSTR_W-1:0] word);
      return word[OTH_W-1:0];
   endfunction

endpackage

// File: rtl/ins_fetch_fifo.sv
// rtl/ins_fetch_fifo.sv - synchronous DEPTH-entry prefetch queue of fetch_entry_t
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wr_entry  enqueue wr_entry; accepted when not full, or when full and popping
//   pop             dequeue head; ignored when empty
//   flush           empty the queue; overrides push and pop
//   head            current head entry (meaningful only when empty=0)
//   count           occupancy, 0..DEPTH
//   full, empty     occupancy flags
module ins_fetch_fifo
   import ins_fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     wr_entry,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full queue still takes a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage needs no reset: the head is only looked at while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: rtl/ins_fetch_unit.sv
// rtl/ins_fetch_unit.sv - decoupled instruction fetch: PC sequencer, memory port, prefetch queue
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fecAbl                   fetch enable; 0 stops new memory requests only
//   redirect, muxFirOut      one-cycle control-flow redirect and its target PC
//   memReq, memAddr          instruction-memory request, address held until memAck
//   memAck, memData          response strobe and instruction word
//   insValid, insReady       head-of-queue handshake towards decode
//   irOutOpe, irOutOth       head instruction [31:26] and [25:0]
//   npcOut                   head fetch PC + PC_STEP
//   qCount                   prefetch queue occupancy
//
// Build option: FETCH_BYPASS_EN - an ack arriving on an empty queue while decode
// is ready is presented to decode combinationally in the same cycle and not stored.
module ins_fetch_unit
   import ins_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4,
   localparam int               CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fecAbl,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] muxFirOut,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   input  logic              memAck,
   input  logic [31:0]       memData,
   output logic              insValid,
   input  logic              insReady,
   output logic [OPC_W-1:0]  irOutOpe,
   output logic [OTH_W-1:0]  irOutOth,
   output logic [ADDR_W-1:0] npcOut,
   output logic [CNT_W-1:0]  qCount
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;          // next address to request (equals memAddr while in REQ)
   logic              ack;
   logic              accept;
   logic              bypass_take;
   logic              q_push;
   logic              q_pop;
   logic              q_empty;
   logic              unused_full;
   logic              issue;
   logic [ADDR_W-1:0] ack_npc;
   logic [ADDR_W-1:0] next_base;
   logic [CNT_W-1:0]  cnt_after;
   fetch_entry_t      wr_entry;
   fetch_entry_t      head;
   fetch_entry_t      out_entry;
   logic              out_valid;

   // An ack only counts against a request we actually have on the bus.
   assign ack     = memReq & memAck;
   // Acks in DROP belong to the stream abandoned by an earlier redirect; an ack
   // coinciding with a redirect is discarded the same way.
   assign accept  = ack & (state == REQ) & ~redirect;
   assign ack_npc = memAddr + ADDR_W'(PC_STEP);

`ifdef FETCH_BYPASS_EN
   assign bypass_take = accept & q_empty & insReady;
`else
   assign bypass_take = 1'b0;
`endif

   assign q_push = accept & ~bypass_take;
   assign q_pop  = insReady & ~q_empty;

   // Occupancy as it will be next cycle with nothing outstanding; a new request
   // may only go out if its response is guaranteed a slot.
   assign cnt_after = redirect ? '0 : (qCount + CNT_W'(q_push) - CNT_W'(q_pop));
   assign issue     = fecAbl & (cnt_after < CNT_W'(DEPTH));

   always_comb begin
      next_base = pc;
      if (redirect)    next_base = muxFirOut;
      else if (accept) next_base = ack_npc;
   end

   assign wr_entry.instr = memData;
   assign wr_entry.npc   = FETCH_ADDR_W'(ack_npc);

   ins_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (q_push),
      .pop      (q_pop),
      .flush    (redirect),
      .wr_entry (wr_entry),
      .head     (head),
      .count    (qCount),
      .full     (unused_full),
      .empty    (q_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         memReq  <= 1'b0;
         memAddr <= RESET_PC;
         pc      <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               // memAddr tracks the PC while idle so a redirect is visible at once.
               pc      <= next_base;
               memAddr <= next_base;
               if (issue) begin
                  memReq <= 1'b1;
                  state  <= REQ;
               end
            end
            REQ, DROP: begin
               if (ack) begin
                  pc      <= next_base;
                  memAddr <= next_base;
                  if (issue) begin
                     memReq <= 1'b1;      // back-to-back request
                     state  <= REQ;
                  end else begin
                     memReq <= 1'b0;
                     state  <= IDLE;
                  end
               end else begin
                  // Request stays on the bus with its address; only the PC moves.
                  pc <= next_base;
                  if (redirect) state <= DROP;
               end
            end
            default: begin
               state  <= IDLE;
               memReq <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      out_valid = ~q_empty;
      out_entry = head;
`ifdef FETCH_BYPASS_EN
      if (bypass_take) begin
         out_valid       = 1'b1;
         out_entry.instr = memData;
         out_entry.npc   = FETCH_ADDR_W'(ack_npc);
      end
`endif
   end

   // Outputs read as zero whenever nothing is presented to decode.
   assign insValid = out_valid;
   assign irOutOpe = out_valid ? opcode_of(out_entry.instr) : '0;
   assign irOutOth = out_valid ? others_of(out_entry.instr) : '0;
   assign npcOut   = out_valid ? ADDR_W'(out_entry.npc) : '0;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// tb/tb_ins_fetch_unit.sv - self-checking bench for ins_fetch_unit
module tb_ins_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0;
   localparam int          DEPTH    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fecAbl;
   logic        redirect;
   logic [31:0] muxFirOut;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memAck;
   logic [31:0] memData;
   logic        insValid;
   logic        insReady;
   logic [5:0]  irOutOpe;
   logic [25:0] irOutOth;
   logic [31:0] npcOut;
   logic [2:0]  qCount;

   int   checks = 0;
   int   errors = 0;
   int   mem_lat = 0;
   int   wait_cnt = 0;
   logic force_ack = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
   endfunction

   // Memory model: ack once the request has waited mem_lat cycles (0 = same cycle).
   assign memAck  = (memReq && (wait_cnt >= mem_lat)) || force_ack;
   assign memData = instr_of(memAddr);

   always @(posedge clk) begin
      if (memReq && !memAck) wait_cnt <= wait_cnt + 1;
      else                   wait_cnt <= 0;
   end

   ins_fetch_unit #(
      .ADDR_W   (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC),
      .PC_STEP  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fecAbl    (fecAbl),
      .redirect  (redirect),
      .muxFirOut (muxFirOut),
      .memReq    (memReq),
      .memAddr   (memAddr),
      .memAck    (memAck),
      .memData   (memData),
      .insValid  (insValid),
      .insReady  (insReady),
      .irOutOpe  (irOutOpe),
      .irOutOth  (irOutOth),
      .npcOut    (npcOut),
      .qCount    (qCount)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at posedge+1 of cycle 0 (first cycle with rst low).
   task automatic do_reset();
      rst = 1'b1; fecAbl = 1'b1; redirect = 1'b0; muxFirOut = '0;
      insReady = 1'b1; force_ack = 1'b0; mem_lat = 0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; fecAbl = 1'b1; redirect = 1'b0; muxFirOut = '0;
      insReady = 1'b1; force_ack = 1'b0; mem_lat = 0;
      repeat (3) tick();
      #4;
      checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq: got %b want 0", memReq); end
      checks++; if (memAddr !== RESET_PC) begin errors++; $display("FAIL reset_memAddr: got %h want %h", memAddr, RESET_PC); end
      checks++; if (insValid !== 1'b0) begin errors++; $display("FAIL reset_insValid: got %b want 0", insValid); end
      checks++; if (irOutOpe !== 6'd0) begin errors++; $display("FAIL reset_irOutOpe: got %h want 0", irOutOpe); end
      checks++; if (irOutOth !== 26'd0) begin errors++; $display("FAIL reset_irOutOth: got %h want 0", irOutOth); end
      checks++; if (npcOut !== 32'd0) begin errors++; $display("FAIL reset_npcOut: got %h want 0", npcOut); end
      checks++; if (qCount !== 3'd0) begin errors++; $display("FAIL reset_qCount: got %0d want 0", qCount); end
      tick();
      rst = 1'b0;
      #4;
      checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL cycle0_memReq: got %b want 0", memReq); end
      tick();
      #4;
      checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL cycle1_memReq: got %b want 1", memReq); end
      checks++; if (memAddr !== RESET_PC) begin errors++; $display("FAIL cycle1_memAddr: got %h want %h", memAddr, RESET_PC); end
      tick();
   endtask

   task automatic test_zero_wait();
      logic [31:0] e;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         #4;
         checks++;
         if (memReq !== (c >= 1)) begin errors++; $display("FAIL zw_memReq c%0d: got %b want %b", c, memReq, (c >= 1)); end
         if (c >= 1 && c <= 4) begin
            e = 32'(4 * (c - 1));
            checks++; if (memAddr !== e) begin errors++; $display("FAIL zw_memAddr c%0d: got %h want %h", c, memAddr, e); end
         end
         checks++;
         if (insValid !== (c >= 2)) begin errors++; $display("FAIL zw_insValid c%0d: got %b want %b", c, insValid, (c >= 2)); end
         if (c >= 2) begin
            e = 32'(4 * (c - 1));
            checks++; if (npcOut !== e) begin errors++; $display("FAIL zw_npcOut c%0d: got %h want %h", c, npcOut, e); end
            e = instr_of(32'(4 * (c - 2)));
            checks++; if ({irOutOpe, irOutOth} !== e) begin errors++; $display("FAIL zw_instr c%0d: got %h want %h", c, {irOutOpe, irOutOth}, e); end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int          acks;
      logic [31:0] npcs[$];
      logic [31:0] first_addr;
      logic        got_addr;
      do_reset();
      insReady = 1'b0;
      acks = 0;
      for (int c = 0; c < 12; c++) begin
         #4;
         if (memReq && memAck) acks++;
         tick();
      end
      #4;
      checks++; if (acks != DEPTH) begin errors++; $display("FAIL bp_acks: got %0d want %0d", acks, DEPTH); end
      checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL bp_memReq_full: got %b want 0", memReq); end
      checks++; if (qCount !== 3'(DEPTH)) begin errors++; $display("FAIL bp_qCount: got %0d want %0d", qCount, DEPTH); end
      tick();
      insReady = 1'b1;
      got_addr = 1'b0;
      first_addr = '0;
      for (int c = 0; c < 12; c++) begin
         #4;
         if (insValid && insReady) npcs.push_back(npcOut);
         if (memReq && memAck && !got_addr) begin first_addr = memAddr; got_addr = 1'b1; end
         tick();
      end
      checks++; if (!got_addr || first_addr !== 32'd16) begin errors++; $display("FAIL bp_resume_addr: got %h (seen %b) want 10", first_addr, got_addr); end
      checks++;
      if (npcs.size() < 6) begin errors++; $display("FAIL bp_drain_count: got %0d want >=6", npcs.size()); end
      else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (npcs[i] !== 32'(4 * (i + 1))) begin errors++; $display("FAIL bp_drain_order[%0d]: got %h want %h", i, npcs[i], 32'(4 * (i + 1))); end
         end
      end
   endtask

   task automatic test_redirect_latency();
      logic [31:0] ack_addrs[$];
      logic [31:0] npcs[$];
      logic [31:0] instrs[$];
      do_reset();
      mem_lat = 3;
      for (int c = 0; c < 20; c++) begin
         redirect = (c == 2);
         muxFirOut = 32'h100;
         #4;
         if (c == 1) begin
            checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL rl_req_rise: got %b want 1", memReq); end
         end
         if (c == 3) begin
            checks++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin errors++; $display("FAIL rl_req_held: got req %b addr %h want 1 0", memReq, memAddr); end
         end
         if (memReq && memAck) ack_addrs.push_back(memAddr);
         if (insValid && insReady) begin npcs.push_back(npcOut); instrs.push_back({irOutOpe, irOutOth}); end
         tick();
      end
      redirect = 1'b0;
      checks++;
      if (ack_addrs.size() < 2) begin errors++; $display("FAIL rl_ack_count: got %0d want >=2", ack_addrs.size()); end
      else if (ack_addrs[0] !== 32'h0 || ack_addrs[1] !== 32'h100) begin
         errors++; $display("FAIL rl_ack_addrs: got %h %h want 0 100", ack_addrs[0], ack_addrs[1]);
      end
      checks++;
      if (npcs.size() < 1) begin errors++; $display("FAIL rl_delivery: got none want npc 104"); end
      else if (npcs[0] !== 32'h104 || instrs[0] !== instr_of(32'h100)) begin
         errors++; $display("FAIL rl_first_npc: got %h/%h want 104/%h", npcs[0], instrs[0], instr_of(32'h100));
      end
   endtask

   task automatic test_redirect_full_and_ack();
      logic found;
      logic got;
      // Full queue, decode popping, redirect in the same cycle.
      do_reset();
      insReady = 1'b0;
      repeat (10) tick();
      #4;
      checks++; if (qCount !== 3'(DEPTH)) begin errors++; $display("FAIL rf_prefill: got %0d want %0d", qCount, DEPTH); end
      tick();
      redirect = 1'b1; muxFirOut = 32'h200; insReady = 1'b1;
      tick();
      redirect = 1'b0; insReady = 1'b0;
      #4;
      checks++; if (qCount !== 3'd0) begin errors++; $display("FAIL rf_qCount: got %0d want 0", qCount); end
      checks++; if (insValid !== 1'b0) begin errors++; $display("FAIL rf_insValid: got %b want 0", insValid); end
      checks++; if (memReq !== 1'b1 || memAddr !== 32'h200) begin errors++; $display("FAIL rf_target: got req %b addr %h want 1 200", memReq, memAddr); end
      // Redirect coinciding with memAck: that ack is lost and no drop remains pending.
      do_reset();
      insReady = 1'b0;
      mem_lat = 2;
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         if (memAck && qCount != 0) begin redirect = 1'b1; muxFirOut = 32'h300; found = 1'b1; end
         tick();
         redirect = 1'b0;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL ra_timeout: got no ack want ack with nonempty queue"); end
      else begin
         #4;
         checks++; if (qCount !== 3'd0) begin errors++; $display("FAIL ra_qCount: got %0d want 0", qCount); end
         checks++; if (insValid !== 1'b0) begin errors++; $display("FAIL ra_insValid: got %b want 0", insValid); end
         checks++; if (memReq !== 1'b1 || memAddr !== 32'h300) begin errors++; $display("FAIL ra_target: got req %b addr %h want 1 300", memReq, memAddr); end
         tick();
         insReady = 1'b1;
         got = 1'b0;
         for (int c = 0; c < 10 && !got; c++) begin
            #4;
            if (insValid) begin
               got = 1'b1;
               checks++;
               if (npcOut !== 32'h304 || {irOutOpe, irOutOth} !== instr_of(32'h300)) begin
                  errors++; $display("FAIL ra_first: got %h/%h want 304/%h", npcOut, {irOutOpe, irOutOth}, instr_of(32'h300));
               end
            end
            tick();
         end
         checks++; if (!got) begin errors++; $display("FAIL ra_delivery_timeout: got none want npc 304"); end
      end
   endtask

   task automatic test_fec_disable();
      int acks;
      int req_cycles;
      do_reset();
      insReady = 1'b0;
      mem_lat = 2;
      tick();
      fecAbl = 1'b0;
      #4;
      checks++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin errors++; $display("FAIL fd_inflight: got req %b addr %h want 1 0", memReq, memAddr); end
      acks = 0; req_cycles = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         #4;
         if (memReq) req_cycles++;
         if (memReq && memAck) acks++;
      end
      checks++; if (acks != 1) begin errors++; $display("FAIL fd_acks: got %0d want 1", acks); end
      checks++; if (req_cycles != 2) begin errors++; $display("FAIL fd_req_cycles: got %0d want 2", req_cycles); end
      checks++; if (qCount !== 3'd1 || insValid !== 1'b1 || npcOut !== 32'h4) begin
         errors++; $display("FAIL fd_queued: got cnt %0d v %b npc %h want 1 1 4", qCount, insValid, npcOut);
      end
      tick();
      fecAbl = 1'b1;
      #4;
      checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL fd_no_early_req: got %b want 0", memReq); end
      tick();
      #4;
      checks++; if (memReq !== 1'b1 || memAddr !== 32'h4) begin errors++; $display("FAIL fd_resume: got req %b addr %h want 1 4", memReq, memAddr); end
      tick();
   endtask

   task automatic test_reset_mid_request();
      do_reset();
      insReady = 1'b0;
      mem_lat = 5;
      tick();
      #4;
      checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL rm_req: got %b want 1", memReq); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; fecAbl = 1'b0; force_ack = 1'b1;
      #4;
      checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL rm_memReq: got %b want 0", memReq); end
      checks++; if (memAddr !== RESET_PC) begin errors++; $display("FAIL rm_memAddr: got %h want %h", memAddr, RESET_PC); end
      tick();
      force_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #4;
         checks++; if (qCount !== 3'd0 || insValid !== 1'b0) begin errors++; $display("FAIL rm_late_ack c%0d: got cnt %0d v %b want 0 0", c, qCount, insValid); end
         tick();
      end
   endtask

   // Reference: after a redirect to T the unit must fetch and deliver T, T+4, ...
   // in order; the one request on the bus at the redirect is discarded.
   task automatic test_random();
      int          model_count;
      logic [31:0] exp_fetch;
      logic [31:0] exp_deliver;
      logic        drop_pending;
      logic        prev_req, prev_ack, prev_fec;
      logic [31:0] prev_addr;
      logic        ack, pop, new_req;
      int          delivered;
      do_reset();
      model_count = 0; exp_fetch = RESET_PC; exp_deliver = RESET_PC; drop_pending = 1'b0;
      prev_req = 1'b0; prev_ack = 1'b0; prev_fec = 1'b1; prev_addr = '0; delivered = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c > 0) begin
            fecAbl   = ($urandom_range(0, 9) != 0);
            insReady = ($urandom_range(0, 2) != 0);
            mem_lat  = $urandom_range(0, 3);
            redirect = ($urandom_range(0, 39) == 0);
            muxFirOut = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
         end
         #4;
         ack = memReq && memAck;
         pop = insValid && insReady;
         new_req = memReq && (!prev_req || prev_ack);
         checks++; if (qCount !== 3'(model_count)) begin errors++; $display("FAIL rnd_qCount c%0d: got %0d want %0d", c, qCount, model_count); end
         checks++; if (insValid !== (model_count != 0)) begin errors++; $display("FAIL rnd_insValid c%0d: got %b want %b", c, insValid, (model_count != 0)); end
         if (insValid) begin
            checks++;
            if (npcOut !== exp_deliver + 32'd4 || {irOutOpe, irOutOth} !== instr_of(exp_deliver)) begin
               errors++; $display("FAIL rnd_head c%0d: got %h/%h want %h/%h", c, npcOut, {irOutOpe, irOutOth}, exp_deliver + 32'd4, instr_of(exp_deliver));
            end
         end
         if (memReq && prev_req && !prev_ack) begin
            checks++; if (memAddr !== prev_addr) begin errors++; $display("FAIL rnd_addr_stable c%0d: got %h want %h", c, memAddr, prev_addr); end
         end
         if (new_req) begin
            checks++; if (!prev_fec || model_count >= DEPTH) begin errors++; $display("FAIL rnd_issue c%0d: got fec %b cnt %0d want 1 <%0d", c, prev_fec, model_count, DEPTH); end
         end
         if (ack && !redirect && !drop_pending) begin
            checks++; if (memAddr !== exp_fetch) begin errors++; $display("FAIL rnd_fetch_addr c%0d: got %h want %h", c, memAddr, exp_fetch); end
         end
         if (redirect) begin
            model_count = 0; exp_fetch = muxFirOut; exp_deliver = muxFirOut;
            drop_pending = memReq && !ack;
         end else begin
            if (ack) begin
               if (drop_pending) drop_pending = 1'b0;
               else begin model_count++; exp_fetch = exp_fetch + 32'd4; end
            end
            if (pop) begin model_count--; exp_deliver = exp_deliver + 32'd4; delivered++; end
         end
         prev_req = memReq; prev_ack = ack; prev_addr = memAddr; prev_fec = fecAbl;
         tick();
      end
      redirect = 1'b0;
      checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_throughput: got %0d want >=200", delivered); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_redirect_latency();
      test_redirect_full_and_ack();
      test_fec_disable();
      test_reset_mid_request();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
